// File: rtl/sh4_fpu_unpack_if.sv
// Bus between the FPU register-file read stage and the sh4_fpu_unpack pipeline.
// Handshake: a transfer happens on a rising edge where valid && ready. A producer holds data stable while valid && !ready.
interface sh4_fpu_unpack_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int LANES  = 1
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int XW = EXP_W + 1;
    localparam int MW = FRAC_W + 1;

    logic                  i_valid;
    logic                  i_ready;
    logic [LANES*W-1:0]    i_data;
    logic                  i_flush;
    logic                  o_valid;
    logic                  o_ready;
    logic [LANES-1:0]      o_sign;
    logic [LANES*XW-1:0]   o_exp;
    logic [LANES*MW-1:0]   o_mant;
    logic [LANES-1:0]      o_zero;
    logic [LANES-1:0]      o_inf;
    logic [LANES-1:0]      o_nan;
    logic [LANES-1:0]      o_snan;
    logic [LANES-1:0]      o_denorm;

    modport master (
        output i_valid, i_data, i_flush, o_ready,
        input  i_ready, o_valid, o_sign, o_exp, o_mant,
        input  o_zero, o_inf, o_nan, o_snan, o_denorm
    );

    modport slave (
        input  i_valid, i_data, i_flush, o_ready,
        output i_ready, o_valid, o_sign, o_exp, o_mant,
        output o_zero, o_inf, o_nan, o_snan, o_denorm
    );
endinterface

// File: rtl/sh4_fpu_unpack.sv
// Two-stage IEEE-754 operand unpacker: S1 classifies each lane, S2 produces unbiased exponent and mantissa.
// Define SH4_FPU_DENORM_EN to normalise subnormals; by default they flush to signed zero (FPSCR.DN=1).
module sh4_fpu_unpack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int LANES  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    sh4_fpu_unpack_if.slave bus
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int XW = EXP_W + 1;
    localparam int MW = FRAC_W + 1;
    localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);

    logic s1_valid;
    logic s2_valid;
    logic s1_advance;
    logic s1_load;
    logic s2_load;

    assign s1_advance  = s1_valid && (!s2_valid || bus.o_ready);
    assign bus.i_ready = !bus.i_flush && (!s1_valid || s1_advance);
    assign s1_load     = bus.i_valid && bus.i_ready;
    assign s2_load     = s1_advance && !bus.i_flush;
    assign bus.o_valid = s2_valid;

    // Flush wins over any accept or output handshake on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (bus.i_flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_load)
                s1_valid <= 1'b1;
            else if (s1_advance)
                s1_valid <= 1'b0;
            if (s1_advance)
                s2_valid <= 1'b1;
            else if (bus.o_ready)
                s2_valid <= 1'b0;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic              op_sign;
        logic [EXP_W-1:0]  op_exp;
        logic [FRAC_W-1:0] op_frac;
        logic              exp_min;
        logic              exp_max;
        logic              frac_nz;
        logic              s1_sign;
        logic              s1_zero;
        logic              s1_denorm;
        logic              s1_inf;
        logic              s1_nan;
        logic              s1_snan;
        logic [EXP_W-1:0]  s1_exp;
        logic [FRAC_W-1:0] s1_frac;
        logic [XW-1:0]     nx_exp;
        logic [MW-1:0]     nx_mant;
        logic              nx_zero;
        logic              r_sign;
        logic              r_zero;
        logic              r_inf;
        logic              r_nan;
        logic              r_snan;
        logic              r_denorm;
        logic [XW-1:0]     r_exp;
        logic [MW-1:0]     r_mant;

        assign {op_sign, op_exp, op_frac} = bus.i_data[l*W +: W];
        assign exp_min = (op_exp == '0);
        assign exp_max = (op_exp == '1);
        assign frac_nz = |op_frac;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_sign   <= 1'b0;
                s1_exp    <= '0;
                s1_frac   <= '0;
                s1_zero   <= 1'b0;
                s1_denorm <= 1'b0;
                s1_inf    <= 1'b0;
                s1_nan    <= 1'b0;
                s1_snan   <= 1'b0;
            end else if (s1_load) begin
                s1_sign   <= op_sign;
                s1_exp    <= op_exp;
                s1_frac   <= op_frac;
                s1_zero   <= exp_min && !frac_nz;
                s1_denorm <= exp_min && frac_nz;
                s1_inf    <= exp_max && !frac_nz;
                s1_nan    <= exp_max && frac_nz;
                s1_snan   <= exp_max && frac_nz && op_frac[FRAC_W-1];
            end
        end

`ifdef SH4_FPU_DENORM_EN
        localparam int LZ_W = $clog2(FRAC_W + 1);
        logic [LZ_W-1:0]   op_lz;
        logic [LZ_W-1:0]   s1_lz;
        logic [LZ_W:0]     shamt;
        logic [FRAC_W-1:0] norm_frac;

        // Highest set bit wins because later iterations overwrite earlier ones.
        always_comb begin
            op_lz = LZ_W'(FRAC_W);
            for (int i = 0; i < FRAC_W; i++) begin
                if (op_frac[i])
                    op_lz = LZ_W'(FRAC_W - 1 - i);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                s1_lz <= '0;
            else if (s1_load)
                s1_lz <= op_lz;
        end

        // Shifting by lz+1 pushes the leading one out; it reappears as the explicit hidden bit.
        assign shamt     = {1'b0, s1_lz} + {{LZ_W{1'b0}}, 1'b1};
        assign norm_frac = s1_frac << shamt;
`endif

        always_comb begin
            nx_zero = s1_zero;
            nx_exp  = {1'b0, s1_exp} - BIAS;
            nx_mant = {!(s1_inf || s1_nan), s1_frac};
            if (s1_zero) begin
                nx_exp  = -BIAS;
                nx_mant = '0;
            end else if (s1_denorm) begin
`ifdef SH4_FPU_DENORM_EN
                nx_exp  = -BIAS - XW'(s1_lz);
                nx_mant = {1'b1, norm_frac};
`else
                nx_zero = 1'b1;
                nx_exp  = -BIAS;
                nx_mant = '0;
`endif
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sign   <= 1'b0;
                r_exp    <= '0;
                r_mant   <= '0;
                r_zero   <= 1'b0;
                r_inf    <= 1'b0;
                r_nan    <= 1'b0;
                r_snan   <= 1'b0;
                r_denorm <= 1'b0;
            end else if (s2_load) begin
                r_sign   <= s1_sign;
                r_exp    <= nx_exp;
                r_mant   <= nx_mant;
                r_zero   <= nx_zero;
                r_inf    <= s1_inf;
                r_nan    <= s1_nan;
                r_snan   <= s1_snan;
                r_denorm <= s1_denorm;
            end
        end

        assign bus.o_sign[l]            = r_sign;
        assign bus.o_exp[l*XW +: XW]    = r_exp;
        assign bus.o_mant[l*MW +: MW]   = r_mant;
        assign bus.o_zero[l]            = r_zero;
        assign bus.o_inf[l]             = r_inf;
        assign bus.o_nan[l]             = r_nan;
        assign bus.o_snan[l]            = r_snan;
        assign bus.o_denorm[l]          = r_denorm;
    end
endmodule

// File: tb/tb_sh4_fpu_unpack.sv
// Bench for sh4_fpu_unpack: vector table, backpressure, flush, async reset, random stream and a double/2-lane instance.
// Honours SH4_FPU_DENORM_EN for the expected subnormal results.
module tb_sh4_fpu_unpack;
    localparam int RW = 39;

    typedef struct packed {
        logic        sign;
        logic [8:0]  ex;
        logic [23:0] mant;
        logic        zero;
        logic        inf;
        logic        nan;
        logic        snan;
        logic        denorm;
    } res_t;

    typedef struct packed {
        logic [31:0] data;
        res_t        want;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sh4_fpu_unpack_if #(.EXP_W(8), .FRAC_W(23), .LANES(1)) bus ();
    sh4_fpu_unpack #(.EXP_W(8), .FRAC_W(23), .LANES(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    sh4_fpu_unpack_if #(.EXP_W(11), .FRAC_W(52), .LANES(2)) bus2 ();
    sh4_fpu_unpack #(.EXP_W(11), .FRAC_W(52), .LANES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    logic [RW-1:0] exp_q[$];
    vec_t vecs[13];

    task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    function automatic res_t mk(input logic s, input logic [8:0] e, input logic [23:0] m, input logic [4:0] fl);
        res_t r;
        r = {s, e, m, fl};
        return r;
    endfunction

    function automatic res_t cur();
        res_t r;
        r = {bus.o_sign[0], bus.o_exp, bus.o_mant, bus.o_zero[0], bus.o_inf[0],
             bus.o_nan[0], bus.o_snan[0], bus.o_denorm[0]};
        return r;
    endfunction

    // Reference model written from the IEEE field definitions with integer arithmetic.
    function automatic res_t model(input logic [31:0] d);
        res_t r;
        logic [7:0]  e;
        logic [22:0] f;
        int p;
        r = '0;
        r.sign = d[31];
        e = d[30:23];
        f = d[22:0];
        p = 0;
        if (e == 8'd0) begin
            if (f == 23'd0) begin
                r.zero = 1'b1;
                r.ex   = 9'(-127);
            end else begin
                r.denorm = 1'b1;
`ifdef SH4_FPU_DENORM_EN
                for (int i = 0; i < 23; i++) if (f[i]) p = i;
                r.ex   = 9'(-127 - (22 - p));
                r.mant = 24'(f) << (23 - p);
`else
                r.zero = 1'b1;
                r.ex   = 9'(-127);
`endif
            end
        end else if (e == 8'hFF) begin
            r.ex   = 9'd128;
            r.mant = {1'b0, f};
            if (f == 23'd0) r.inf = 1'b1;
            else begin
                r.nan  = 1'b1;
                r.snan = f[22];
            end
        end else begin
            r.ex   = 9'(int'(e) - 127);
            r.mant = {1'b1, f};
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] d;
        d = $urandom;
        case ($urandom_range(0, 5))
            0: d[30:23] = 8'h00;
            1: d[30:23] = 8'hFF;
            2: d[30:0]  = 31'd0;
            3: begin
                d[30:23] = 8'h00;
                d[22:0]  = 23'(1) << $urandom_range(0, 22);
            end
            default: ;
        endcase
        return d;
    endfunction

    // Monitor: every valid output is either handed off (pop) or stalled (must equal the head).
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.o_valid) begin
            if (exp_q.size() == 0)
                check_val("spurious_o_valid", 128'(bus.o_valid), 128'(0));
            else if (bus.o_ready) begin
                check_val("out_data", 128'(cur()), 128'(exp_q.pop_front()));
                n_out++;
            end else
                check_val("stall_hold", 128'(cur()), 128'(exp_q[0]));
        end
    end

    // Must be called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic [31:0] d, input res_t want);
        int b = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        @(negedge clk);
        while (!bus.i_ready && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (!bus.i_ready)
            check_val("send_timeout_i_ready", 128'(bus.i_ready), 128'(1));
        else
            exp_q.push_back(want);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        bus.o_ready = 1'b1;
        while (exp_q.size() != 0 && b < 60) begin
            @(negedge clk);
            b++;
        end
        @(posedge clk);
        #1;
        check_val("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1);
    end

    initial begin
        bit saw_block;
        bit done;
        int n0;
        int b;

        vecs[0]  = '{32'h3F800000, mk(1'b0, 9'h000, 24'h800000, 5'b00000)};
        vecs[1]  = '{32'hC0490FDB, mk(1'b1, 9'h001, 24'hC90FDB, 5'b00000)};
        vecs[2]  = '{32'h7F800000, mk(1'b0, 9'h080, 24'h000000, 5'b01000)};
        vecs[3]  = '{32'h7FC00000, mk(1'b0, 9'h080, 24'h400000, 5'b00110)};
        vecs[4]  = '{32'h7F800001, mk(1'b0, 9'h080, 24'h000001, 5'b00100)};
        vecs[5]  = '{32'h80000000, mk(1'b1, 9'h181, 24'h000000, 5'b10000)};
`ifdef SH4_FPU_DENORM_EN
        vecs[6]  = '{32'h00000001, mk(1'b0, 9'h16B, 24'h800000, 5'b00001)};
        vecs[7]  = '{32'h00400000, mk(1'b0, 9'h181, 24'h800000, 5'b00001)};
        vecs[12] = '{32'h80000003, mk(1'b1, 9'h16C, 24'hC00000, 5'b00001)};
`else
        vecs[6]  = '{32'h00000001, mk(1'b0, 9'h181, 24'h000000, 5'b10001)};
        vecs[7]  = '{32'h00400000, mk(1'b0, 9'h181, 24'h000000, 5'b10001)};
        vecs[12] = '{32'h80000003, mk(1'b1, 9'h181, 24'h000000, 5'b10001)};
`endif
        vecs[8]  = '{32'h00000000, mk(1'b0, 9'h181, 24'h000000, 5'b10000)};
        vecs[9]  = '{32'h7F7FFFFF, mk(1'b0, 9'h07F, 24'hFFFFFF, 5'b00000)};
        vecs[10] = '{32'h00800000, mk(1'b0, 9'h182, 24'h800000, 5'b00000)};
        vecs[11] = '{32'hFFFFFFFF, mk(1'b1, 9'h080, 24'h7FFFFF, 5'b00110)};

        // Clock/reset
        rst_n        = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_data   = '0;
        bus.i_flush  = 1'b0;
        bus.o_ready  = 1'b1;
        bus2.i_valid = 1'b0;
        bus2.i_data  = '0;
        bus2.i_flush = 1'b0;
        bus2.o_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_o_valid", 128'(bus.o_valid), 128'(0));
        check_val("reset_outputs", 128'(cur()), 128'(0));
        rst_n = 1'b1;
        #1;
        check_val("reset_i_ready", 128'(bus.i_ready), 128'(1));
        @(posedge clk);
        #1;

        // Vector table, back-to-back
        for (int k = 0; k < 13; k++) send(vecs[k].data, vecs[k].want);
        drain();

        // Backpressure: 8 back-to-back, o_ready low for cycles 3..6
        saw_block = 1'b0;
        n0 = n_out;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    logic [31:0] d;
                    d = rand_op();
                    send(d, model(d));
                end
            end
            begin
                for (int c = 0; c < 10; c++) begin
                    @(posedge clk);
                    #1;
                    bus.o_ready = !(c >= 1 && c <= 4);
                end
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    @(negedge clk);
                    if (bus.o_valid && !bus.o_ready && !bus.i_ready) saw_block = 1'b1;
                end
            end
        join
        drain();
        check_val("bp_i_ready_dropped", 128'(saw_block), 128'(1));
        check_val("bp_count", 128'(n_out - n0), 128'(8));

        // Flush with both stages full and a concurrent input
        bus.o_ready = 1'b0;
        send(32'h40000000, model(32'h40000000));
        send(32'h40400000, model(32'h40400000));
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h40800000;
        bus.i_flush = 1'b1;
        @(negedge clk);
        check_val("full_flush_i_ready", 128'(bus.i_ready), 128'(0));
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        exp_q.delete();
        check_val("flush_o_valid", 128'(bus.o_valid), 128'(0));
        n0 = n_out;
        bus.o_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_val("flush_discard_count", 128'(n_out - n0), 128'(0));
        check_val("flush_idle_o_valid", 128'(bus.o_valid), 128'(0));

        // Asynchronous reset mid-stream
        send(32'h3F800000, vecs[0].want);
        send(32'hC0490FDB, vecs[1].want);
        b = 0;
        @(negedge clk);
        while (!bus.o_valid && b < 10) begin
            @(negedge clk);
            b++;
        end
        @(posedge clk);
        #2;
        check_val("pre_reset_o_valid", 128'(bus.o_valid), 128'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check_val("async_reset_o_valid", 128'(bus.o_valid), 128'(0));
        check_val("async_reset_outputs", 128'(cur()), 128'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("post_reset_i_ready", 128'(bus.i_ready), 128'(1));
        @(posedge clk);
        #1;

        // Random stream with random backpressure
        done = 1'b0;
        n0 = n_out;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    logic [31:0] d;
                    d = rand_op();
                    send(d, model(d));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.o_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        check_val("rand_count", 128'(n_out - n0), 128'(40));

        // Double precision, two lanes
        @(negedge clk);
        check_val("dbl_i_ready", 128'(bus2.i_ready), 128'(1));
        @(posedge clk);
        #1;
        bus2.i_data  = {64'h0000000000000001, 64'h3FF0000000000000};
        bus2.i_valid = 1'b1;
        @(posedge clk);
        #1;
        bus2.i_valid = 1'b0;
        b = 0;
        @(negedge clk);
        while (!bus2.o_valid && b < 10) begin
            @(negedge clk);
            b++;
        end
        check_val("dbl_o_valid", 128'(bus2.o_valid), 128'(1));
        check_val("dbl_l0_exp", 128'(bus2.o_exp[11:0]), 128'(12'h000));
        check_val("dbl_l0_mant", 128'(bus2.o_mant[52:0]), 128'(53'h10000000000000));
        check_val("dbl_l0_flags", 128'({bus2.o_zero[0], bus2.o_inf[0], bus2.o_nan[0], bus2.o_denorm[0]}), 128'(0));
        check_val("dbl_sign", 128'(bus2.o_sign), 128'(2'b00));
`ifdef SH4_FPU_DENORM_EN
        check_val("dbl_l1_exp", 128'(bus2.o_exp[23:12]), 128'(12'hBCE));
        check_val("dbl_l1_mant", 128'(bus2.o_mant[105:53]), 128'(53'h10000000000000));
        check_val("dbl_l1_zero_denorm", 128'({bus2.o_zero[1], bus2.o_denorm[1]}), 128'(2'b01));
`else
        check_val("dbl_l1_exp", 128'(bus2.o_exp[23:12]), 128'(12'hC01));
        check_val("dbl_l1_mant", 128'(bus2.o_mant[105:53]), 128'(0));
        check_val("dbl_l1_zero_denorm", 128'({bus2.o_zero[1], bus2.o_denorm[1]}), 128'(2'b11));
`endif
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
